// File: rtl/paddle_scheduler.sv
// Per-frame paddle position controller: picks the active player's source on each VSYNC,
// latches it as pos_q, then generates PAD_OUT by counting HSYNC edges. Optional macro: PADDLE_SLEW_EN.
module paddle_scheduler #(
  parameter int DELTA_SLOW = 4,
  parameter int DELTA_FAST = 8,
  parameter int CENTER     = 114,
  parameter int SLEW_MAX   = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       pad_en_n,
  input  logic       player2,
  input  logic       speed,
  input  logic [2:0] p1_src,
  input  logic [2:0] p2_src,
  input  logic       p1_left,
  input  logic       p1_right,
  input  logic       p2_left,
  input  logic       p2_right,
  input  logic [7:0] p1_ax,
  input  logic [7:0] p1_ay,
  input  logic [7:0] p1_pad,
  input  logic [7:0] p2_ax,
  input  logic [7:0] p2_ay,
  input  logic [7:0] p2_pad,
  output logic       pad_out,
  output logic [7:0] pos_q,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, UPDATE, ARM, COUNT} state_t;

  state_t     state, state_nx;
  logic       hs_s, hs_p, hs_edge;
  logic       vs_s, vs_p, vs_edge;
  logic [7:0] dpos1, dpos2, cnt;

  logic [2:0] src;
  logic       left, right;
  logic [7:0] ax, ay, pad, dpos_cur, dpos_new, target, pos_nx;
  logic [8:0] delta, sum;

  // Frame sequencing: a vsync edge always restarts the frame, even mid-count.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (vs_edge) state_nx = UPDATE;
      UPDATE: state_nx = ARM;
      ARM:    if (vs_edge) state_nx = UPDATE;
              else if (pad_en_n) state_nx = COUNT;
      COUNT:  if (vs_edge) state_nx = UPDATE;
              else if (!pad_en_n) state_nx = ARM;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    src      = player2 ? p2_src   : p1_src;
    left     = player2 ? p2_left  : p1_left;
    right    = player2 ? p2_right : p1_right;
    ax       = player2 ? p2_ax    : p1_ax;
    ay       = player2 ? p2_ay    : p1_ay;
    pad      = player2 ? p2_pad   : p1_pad;
    dpos_cur = player2 ? dpos2    : dpos1;
    delta    = speed ? 9'(DELTA_FAST) : 9'(DELTA_SLOW);
    sum      = {1'b0, dpos_cur} + delta;
    dpos_new = dpos_cur;
    if (left && !right)
      dpos_new = sum[8] ? 8'hFF : sum[7:0];
    else if (right && !left)
      dpos_new = ({1'b0, dpos_cur} < delta) ? 8'h00 : 8'(dpos_cur - delta[7:0]);
    // Digital selection deliberately sees the pre-step position.
    case (src)
      3'd0:    target = dpos_cur;
      3'd1:    target = ~ax;
      3'd2:    target = ax;
      3'd3:    target = ~ay;
      3'd4:    target = ay;
      3'd5:    target = ~pad;
      3'd6:    target = pad;
      default: target = 8'(CENTER);
    endcase
  end

`ifdef PADDLE_SLEW_EN
  logic       last_p2;
  logic [8:0] gap;

  always_comb begin
    pos_nx = target;
    gap    = 9'd0;
    if (player2 == last_p2) begin
      if (target > pos_q) begin
        gap = {1'b0, target} - {1'b0, pos_q};
        if (gap > 9'(SLEW_MAX)) pos_nx = 8'(pos_q + 8'(SLEW_MAX));
      end else begin
        gap = {1'b0, pos_q} - {1'b0, target};
        if (gap > 9'(SLEW_MAX)) pos_nx = 8'(pos_q - 8'(SLEW_MAX));
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) last_p2 <= 1'b0;
    else if (state == UPDATE) last_p2 <= player2;
  end
`else
  assign pos_nx = target;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state   <= IDLE;
      hs_s    <= 1'b0;
      hs_p    <= 1'b0;
      hs_edge <= 1'b0;
      vs_s    <= 1'b0;
      vs_p    <= 1'b0;
      vs_edge <= 1'b0;
      dpos1   <= 8'(CENTER);
      dpos2   <= 8'(CENTER);
      pos_q   <= 8'(CENTER);
      cnt     <= 8'd0;
      pad_out <= 1'b0;
    end else begin
      state   <= state_nx;
      hs_s    <= hsync;
      hs_p    <= hs_s;
      hs_edge <= hs_s & ~hs_p;
      vs_s    <= vsync;
      vs_p    <= vs_s;
      vs_edge <= vs_s & ~vs_p;
      if (state == UPDATE) begin
        pos_q <= pos_nx;
        if (player2) dpos2 <= dpos_new;
        else         dpos1 <= dpos_new;
      end
      // A coincident vsync edge drops the hsync increment since the frame restarts.
      if ((state == ARM || state == COUNT) && !pad_en_n)
        cnt <= 8'd0;
      else if (state == COUNT && hs_edge && !vs_edge && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
      pad_out <= (state == ARM || state == COUNT) ? (cnt < pos_q) : 1'b0;
    end
  end

  assign busy = (state == ARM) || (state == COUNT);

endmodule

// File: tb/tb_paddle_scheduler.sv
// Directed bench for paddle_scheduler: frame sequencing, digital stepping, source select and line counting.
module tb_paddle_scheduler;

  logic       clk_sys = 1'b0;
  logic       reset_n, hsync, vsync, pad_en_n, player2, speed;
  logic [2:0] p1_src, p2_src;
  logic       p1_left, p1_right, p2_left, p2_right;
  logic [7:0] p1_ax, p1_ay, p1_pad, p2_ax, p2_ay, p2_pad;
  logic       pad_out, busy;
  logic [7:0] pos_q;

  int n_cmp = 0;
  int n_err = 0;
  int dp1   = 114;
  int exp_pos;

  always #5 clk_sys = ~clk_sys;

  paddle_scheduler dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .hsync(hsync), .vsync(vsync),
    .pad_en_n(pad_en_n), .player2(player2), .speed(speed),
    .p1_src(p1_src), .p2_src(p2_src),
    .p1_left(p1_left), .p1_right(p1_right), .p2_left(p2_left), .p2_right(p2_right),
    .p1_ax(p1_ax), .p1_ay(p1_ay), .p1_pad(p1_pad),
    .p2_ax(p2_ax), .p2_ay(p2_ay), .p2_pad(p2_pad),
    .pad_out(pad_out), .pos_q(pos_q), .busy(busy)
  );

  // One-cycle vsync pulse, then wait until pos_q has been reloaded.
  task automatic frame();
    @(negedge clk_sys) vsync = 1'b1;
    @(negedge clk_sys) vsync = 1'b0;
    repeat (4) @(negedge clk_sys);
  endtask

  task automatic hs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys) hsync = 1'b1;
      @(negedge clk_sys) hsync = 1'b0;
    end
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk_sys);
    n_cmp++; if (pos_q !== 8'd114) begin n_err++; $display("FAIL reset_pos: got %0d want 114", pos_q); end
    n_cmp++; if (pad_out !== 1'b0) begin n_err++; $display("FAIL reset_pad_out: got %b want 0", pad_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    @(negedge clk_sys);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_count_window();
    p1_src = 3'd0;
    frame();
    n_cmp++; if (pos_q !== 8'd114) begin n_err++; $display("FAIL first_pos: got %0d want 114", pos_q); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy: got %b want 1", busy); end
    pad_en_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (pad_out !== 1'b1) begin n_err++; $display("FAIL window_start: got %b want 1", pad_out); end
    hs_pulses(113);
    n_cmp++; if (pad_out !== 1'b1) begin n_err++; $display("FAIL window_113: got %b want 1", pad_out); end
    hs_pulses(1);
    n_cmp++; if (pad_out !== 1'b0) begin n_err++; $display("FAIL window_114: got %b want 0", pad_out); end
    pad_en_n = 1'b0;
  endtask

  task automatic test_digital_steps();
    speed = 1'b1;
    p1_left = 1'b1;
    for (int f = 0; f < 20; f++) begin
      exp_pos = dp1;
      dp1 = (dp1 + 8 > 255) ? 255 : dp1 + 8;
      frame();
      n_cmp++; if (pos_q !== 8'(exp_pos)) begin n_err++; $display("FAIL left_frame%0d: got %0d want %0d", f, pos_q, exp_pos); end
    end
    p1_left = 1'b0;
    p1_right = 1'b1;
    for (int f = 0; f < 40; f++) begin
      exp_pos = dp1;
      dp1 = (dp1 < 8) ? 0 : dp1 - 8;
      frame();
      n_cmp++; if (pos_q !== 8'(exp_pos)) begin n_err++; $display("FAIL right_frame%0d: got %0d want %0d", f, pos_q, exp_pos); end
    end
    p1_left = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame();
      n_cmp++; if (pos_q !== 8'(dp1)) begin n_err++; $display("FAIL both_frame%0d: got %0d want %0d", f, pos_q, dp1); end
    end
    p1_left = 1'b0;
    p1_right = 1'b0;
  endtask

  task automatic test_analog_select();
    p1_ax = 8'h20;
    p1_src = 3'd1;
    frame();
    n_cmp++; if (pos_q !== 8'hDF) begin n_err++; $display("FAIL inv_ax: got %h want df", pos_q); end
    p1_src = 3'd2;
    frame();
    n_cmp++; if (pos_q !== 8'h20) begin n_err++; $display("FAIL ax: got %h want 20", pos_q); end
    p1_ay = 8'h33;
    p1_src = 3'd3;
    frame();
    n_cmp++; if (pos_q !== 8'hCC) begin n_err++; $display("FAIL inv_ay: got %h want cc", pos_q); end
    p1_pad = 8'h81;
    p1_src = 3'd5;
    frame();
    n_cmp++; if (pos_q !== 8'h7E) begin n_err++; $display("FAIL inv_pad: got %h want 7e", pos_q); end
    p1_src = 3'd7;
    frame();
    n_cmp++; if (pos_q !== 8'd114) begin n_err++; $display("FAIL center: got %0d want 114", pos_q); end
  endtask

  task automatic test_player_switch();
    p2_src = 3'd6;
    p2_pad = 8'h50;
    pad_en_n = 1'b1;
    repeat (3) @(negedge clk_sys);
    player2 = 1'b1;
    p1_left = 1'b1;
    repeat (6) @(negedge clk_sys);
    n_cmp++; if (pos_q !== 8'd114) begin n_err++; $display("FAIL p2_midframe: got %0d want 114", pos_q); end
    frame();
    n_cmp++; if (pos_q !== 8'h50) begin n_err++; $display("FAIL p2_pad: got %h want 50", pos_q); end
    player2 = 1'b0;
    p1_left = 1'b0;
    p1_src = 3'd0;
    frame();
    n_cmp++; if (pos_q !== 8'(dp1)) begin n_err++; $display("FAIL p1_dpos_held: got %0d want %0d", pos_q, dp1); end
    pad_en_n = 1'b0;
  endtask

  task automatic test_cnt_saturate();
    p1_src = 3'd7;
    frame();
    pad_en_n = 1'b1;
    hs_pulses(300);
    n_cmp++; if (pad_out !== 1'b0) begin n_err++; $display("FAIL cnt_saturate: got %b want 0", pad_out); end
    @(negedge clk_sys) pad_en_n = 1'b0;
    @(negedge clk_sys) pad_en_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    n_cmp++; if (pad_out !== 1'b1) begin n_err++; $display("FAIL cnt_clear: got %b want 1", pad_out); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL count_busy: got %b want 1", busy); end
    pad_en_n = 1'b0;
  endtask

  task automatic test_same_cycle_edges();
    p1_pad = 8'd10;
    p1_src = 3'd6;
    frame();
    n_cmp++; if (pos_q !== 8'd10) begin n_err++; $display("FAIL pad10: got %0d want 10", pos_q); end
    pad_en_n = 1'b1;
    hs_pulses(9);
    n_cmp++; if (pad_out !== 1'b1) begin n_err++; $display("FAIL cnt9: got %b want 1", pad_out); end
    @(negedge clk_sys) begin hsync = 1'b1; vsync = 1'b1; end
    @(negedge clk_sys) begin hsync = 1'b0; vsync = 1'b0; end
    repeat (4) @(negedge clk_sys);
    n_cmp++; if (pad_out !== 1'b1) begin n_err++; $display("FAIL hs_dropped: got %b want 1", pad_out); end
    hs_pulses(1);
    n_cmp++; if (pad_out !== 1'b0) begin n_err++; $display("FAIL cnt10: got %b want 0", pad_out); end
  endtask

  task automatic test_reset_mid_count();
    @(negedge clk_sys) reset_n = 1'b0;
    @(negedge clk_sys);
    n_cmp++; if (pos_q !== 8'd114) begin n_err++; $display("FAIL midrst_pos: got %0d want 114", pos_q); end
    n_cmp++; if (pad_out !== 1'b0) begin n_err++; $display("FAIL midrst_pad_out: got %b want 0", pad_out); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b want 0", busy); end
    reset_n = 1'b1;
    pad_en_n = 1'b0;
    dp1 = 114;
    p1_src = 3'd0;
    frame();
    n_cmp++; if (pos_q !== 8'(dp1)) begin n_err++; $display("FAIL midrst_dpos: got %0d want %0d", pos_q, dp1); end
  endtask

  initial begin
    reset_n = 1'b0; hsync = 1'b0; vsync = 1'b0; pad_en_n = 1'b0;
    player2 = 1'b0; speed = 1'b0;
    p1_src = 3'd0; p2_src = 3'd0;
    p1_left = 1'b0; p1_right = 1'b0; p2_left = 1'b0; p2_right = 1'b0;
    p1_ax = 8'h00; p1_ay = 8'h00; p1_pad = 8'h00;
    p2_ax = 8'h00; p2_ay = 8'h00; p2_pad = 8'h00;
    test_reset();
    test_count_window();
    test_digital_steps();
    test_analog_select();
    test_player_switch();
    test_cnt_saturate();
    test_same_cycle_edges();
    test_reset_mid_count();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paddle_scheduler.md
# paddle_scheduler

Per-frame paddle position controller for the Breakout core. Once per frame, on the VSYNC rising edge, it selects the active player's control source (digital, analog X/Y, or paddle) and steps the digital positions. It latches the result as the frame's paddle target. It then counts horizontal lines inside the game's PAD_EN_N window and drives PAD_OUT to the game logic. It sits between the input mixing (joystick/keyboard/paddle) and the breakout_top instance, replacing ad-hoc per-line compare logic with one sequenced, clamped datapath.

## Interface
Parameters:
- DELTA_SLOW, 4, digital step per frame when speed=0
- DELTA_FAST, 8, digital step per frame when speed=1
- CENTER, 114, reset/default position
- SLEW_MAX, 16, maximum per-frame change of pos_q (only with PADDLE_SLEW_EN)

Ports (one clock; reset is synchronous and active-low):
- clk_sys  in  1  system clock (57.272 MHz)
- reset_n  in  1  synchronous active-low reset
- hsync  in  1  game HSYNC
- vsync  in  1  game VSYNC
- pad_en_n  in  1  game PAD_EN_N; low = line counter held clear
- player2  in  1  game PLAYER2; selects the active player
- speed  in  1  0 = DELTA_SLOW, 1 = DELTA_FAST
- p1_src, p2_src  in  3  source select per player
- p1_left, p1_right, p2_left, p2_right  in  1  digital inputs
- p1_ax, p1_ay, p1_pad, p2_ax, p2_ay, p2_pad  in  8  offset-binary analog X, analog Y and paddle values
- pad_out  out  1  registered: line count < pos_q
- pos_q  out  8  position latched for the current frame
- busy  out  1  high in ARM and COUNT

## Operation
- Edge detect: hsync and vsync are registered once; an edge is a sample that is 1 while the previous sample was 0.
- FSM states: IDLE, UPDATE, ARM, COUNT. Reset state is IDLE.
  - IDLE → UPDATE on a vsync edge.
  - UPDATE lasts one cycle, then goes to ARM.
  - ARM → COUNT when pad_en_n=1.
  - COUNT → ARM when pad_en_n=0.
  - ARM or COUNT → UPDATE on a vsync edge. The vsync edge has priority over pad_en_n.
- UPDATE, digital step: only the active player's digital position dpos (9-bit arithmetic) changes.
  - left only: dpos = min(dpos + delta, 255).
  - right only: dpos = max(dpos − delta, 0).
  - both pressed or neither: unchanged.
  - The inactive player's dpos holds its value.
- UPDATE, target selection by src:
  - 0: dpos
  - 1: ~ax
  - 2: ax
  - 3: ~ay
  - 4: ay
  - 5: ~pad
  - 6: pad
  - 7: CENTER
  - Digital selection uses the dpos value from before the step, so the step appears one frame later.
- Counter cnt (8-bit):
  - cleared while pad_en_n=0 in ARM or COUNT;
  - +1 on an hsync edge in COUNT;
  - saturates at 255 (no wrap).
- pad_out:
  - equals (cnt < pos_q), registered, in ARM and COUNT;
  - 0 in IDLE and UPDATE;
  - pos_q=0 gives pad_out=0 for the whole frame.
- Reset values: state=IDLE, pos_q=CENTER, both dpos=CENTER, cnt=0, pad_out=0, busy=0. Reset asserted mid-frame aborts the FSM and restores these values on the next clock.

## Timing
- vsync goes high at input sample cycle k: edge detected at k+1, state=UPDATE at k+2, pos_q and dpos updated at k+3.
- hsync edge detected at cycle j: cnt updates at j+1, pad_out reflects it at j+2.
- pad_en_n falling: cnt=0 one cycle after the sample, pad_out follows one cycle later.
- A player2 change takes effect at the next UPDATE only; no mid-frame source switch.
- hsync and vsync edges in the same cycle: both are processed. The vsync edge wins the state transition, and the hsync increment is dropped (state leaves COUNT).

## Configuration
- PADDLE_SLEW_EN defined: in UPDATE, pos_q moves toward the target by at most SLEW_MAX, with no overshoot. If player2 differs from its value at the previous UPDATE (tracked by a register), pos_q loads the target directly.
- PADDLE_SLEW_EN undefined: pos_q = target in every UPDATE. The slew logic and the player-tracking register are not built.

## Test plan
- Reset then one vsync with p1_src=0 and no buttons → pos_q=114; in COUNT, pad_out=1 for the first 114 hsync edges, then 0.
- p1_src=0, speed=1, p1_left held for 20 frames → dpos saturates at 255 and stays there; p1_right held for 40 frames → dpos reaches 0 and stays there; both held → dpos unchanged.
- p1_src=1, p1_ax=0x20 → pos_q=0xDF; switch to p1_src=2 → pos_q=0x20 at the next UPDATE; src=7 → pos_q=114.
- player2 toggles mid-COUNT with p2_src=6, p2_pad=0x50 → pos_q stays unchanged until the next vsync, then becomes 0x50; p1's dpos is unaffected.
- 300 hsync edges in COUNT → cnt saturates at 255; pad_en_n pulsed low → cnt=0 and pad_out=1 (when pos_q>0). Reset_n low mid-COUNT → all outputs return to reset values on the next clock.
- With PADDLE_SLEW_EN, ax stepping 0x00→0xFF with the same player → pos_q increases by 16 per frame, with no overshoot at the target; a player change → pos_q loads the target immediately.
